// File: rtl/gcd_pkg.sv
// Shared types for the GCD fraction-reduction block: FSM states and the job bundle.
package gcd_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } frac_state_t;

    // Job fields are sized at the default width; the top casts to/from its WIDTH.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] num;
        logic [DEF_WIDTH-1:0] den;
        logic [DEF_WIDTH-1:0] gcd;
    } frac_job_t;

endpackage

// File: rtl/gcd_seq_div.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Results hold after done until the next start.
module gcd_seq_div
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH:0]   remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // The quotient register doubles as the dividend shifter: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    always_comb begin
        shifted = {remainder[WIDTH-1:0], quotient[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvsr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dvsr      <= '0;
            bit_cnt   <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            done      <= 1'b0;
            quotient  <= dividend;
            remainder <= '0;
            dvsr      <= divisor;
            bit_cnt   <= '0;
        end else if (busy) begin
            if (trial[WIDTH+1]) begin
                remainder <= shifted;
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end else begin
                remainder <= trial[WIDTH:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end
            if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/gcd_frac_reduce.sv
// Reduces num:den by a supplied GCD using two parallel sequential dividers,
// with a one-cycle bypass for gcd==0 (error) and optionally gcd==1.
module gcd_frac_reduce
    import gcd_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter bit BYPASS_1 = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num_i,
    input  logic [WIDTH-1:0] den_i,
    input  logic [WIDTH-1:0] gcd_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] num_o,
    output logic [WIDTH-1:0] den_o,
    output logic             div_err,
    output logic             out_valid,
    input  logic             out_ready
);

    frac_state_t state, state_nxt;
    frac_job_t   job;

    logic             accept;
    logic             take_bypass;
    logic             div_start;
    logic             div_done;
    logic             num_busy, den_busy;
    logic             num_done, den_done;
    logic [WIDTH-1:0] num_quo, den_quo;
    logic [WIDTH:0]   num_rem, den_rem;

    always_comb begin
        in_ready    = (state == IDLE) && !num_busy && !den_busy;
        accept      = in_valid && in_ready;
        take_bypass = (gcd_i == '0) || (BYPASS_1 && (gcd_i == WIDTH'(1)));
        div_done    = num_done && den_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (take_bypass) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = DIV;
                        div_start = 1'b1;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job <= '0;
        end else if (accept) begin
            job <= '{num: DEF_WIDTH'(num_i), den: DEF_WIDTH'(den_i), gcd: DEF_WIDTH'(gcd_i)};
        end
    end

    // A bypassed job reaches DONE with out_valid still low; it is presented from
    // the latched job one edge later. Divided jobs are presented on leaving DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_o     <= '0;
            den_o     <= '0;
            div_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if ((state == DIV) && div_done) begin
            num_o     <= num_quo;
            den_o     <= den_quo;
            div_err   <= (|num_rem) || (|den_rem);
            out_valid <= 1'b1;
        end else if ((state == DONE) && !out_valid) begin
            num_o     <= WIDTH'(job.num);
            den_o     <= WIDTH'(job.den);
            div_err   <= (job.gcd == '0);
            out_valid <= 1'b1;
        end else if ((state == DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    gcd_seq_div #(.WIDTH(WIDTH)) u_num_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (num_i),
        .divisor   (gcd_i),
        .busy      (num_busy),
        .done      (num_done),
        .quotient  (num_quo),
        .remainder (num_rem)
    );

    gcd_seq_div #(.WIDTH(WIDTH)) u_den_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (den_i),
        .divisor   (gcd_i),
        .busy      (den_busy),
        .done      (den_done),
        .quotient  (den_quo),
        .remainder (den_rem)
    );

endmodule

// File: tb/tb_gcd_frac_reduce.sv
// Self-checking bench for gcd_frac_reduce: directed vector table, handshake/reset
// sequences, and randomized jobs against an arithmetic reference model.
module tb_gcd_frac_reduce;

    localparam int WIDTH    = 16;
    localparam int FULL_LAT = WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] num_i, den_i, gcd_i;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num_o, den_o;
    logic             div_err;
    logic             out_valid;
    logic             out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int num;
        int den;
        int gcd;
        int exp_num;
        int exp_den;
        int exp_err;
        int exp_lat;
    } vec_t;

    vec_t vecs[10];

    gcd_frac_reduce #(.WIDTH(WIDTH), .BYPASS_1(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .num_i     (num_i),
        .den_i     (den_i),
        .gcd_i     (gcd_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_o     (num_o),
        .den_o     (den_o),
        .div_err   (div_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: plain integer division with the bypass rules applied first.
    function automatic void model(input int n, input int d, input int g,
                                  output int en, output int ed, output int ee, output int elat);
        if (g == 0) begin
            en = n; ed = d; ee = 1; elat = 1;
        end else if (g == 1) begin
            en = n; ed = d; ee = 0; elat = 1;
        end else begin
            en   = n / g;
            ed   = d / g;
            ee   = ((n % g) != 0 || (d % g) != 0) ? 1 : 0;
            elat = FULL_LAT;
        end
    endfunction

    // Called at #1 after a rising edge; returns at #1 after the accepting edge.
    task automatic applyStimulus(input int n, input int d, input int g);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("in_ready_before_accept", int'(in_ready), 1);
        num_i    = WIDTH'(n);
        den_i    = WIDTH'(d);
        gcd_i    = WIDTH'(g);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat, output int gn, output int gd, output int ge);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        gn = int'(num_o);
        gd = int'(den_o);
        ge = out_valid ? int'(div_err) : -1;
    endtask

    task automatic runJob(input string tag, input int n, input int d, input int g,
                          input int en, input int ed, input int ee, input int elat);
        int lat, gn, gd, ge;
        applyStimulus(n, d, g);
        waitResult(lat, gn, gd, ge);
        checkOutput({tag, "_num"}, gn, en);
        checkOutput({tag, "_den"}, gd, ed);
        checkOutput({tag, "_err"}, ge, ee);
        checkOutput({tag, "_lat"}, lat, elat);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, gn, gd, ge;
        int n, d, g, mode, en, ed, ee, elat;

        vecs[0] = '{42, 18, 6, 7, 3, 0, FULL_LAT};
        vecs[1] = '{13, 7, 1, 13, 7, 0, 1};
        vecs[2] = '{0, 7, 0, 0, 7, 1, 1};
        vecs[3] = '{620, 620, 620, 1, 1, 0, FULL_LAT};
        vecs[4] = '{42, 18, 4, 10, 4, 1, FULL_LAT};
        vecs[5] = '{100, 75, 25, 4, 3, 0, FULL_LAT};
        vecs[6] = '{0, 0, 5, 0, 0, 0, FULL_LAT};
        vecs[7] = '{65535, 65535, 65535, 1, 1, 0, FULL_LAT};
        vecs[8] = '{65535, 1, 1, 65535, 1, 0, 1};
        vecs[9] = '{65534, 65535, 2, 32767, 32767, 1, FULL_LAT};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        num_i     = '0;
        den_i     = '0;
        gcd_i     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_num_o", int'(num_o), 0);
        checkOutput("reset_den_o", int'(den_o), 0);
        checkOutput("reset_div_err", int'(div_err), 0);

        for (int i = 0; i < 10; i++) begin
            runJob($sformatf("vec%0d", i), vecs[i].num, vecs[i].den, vecs[i].gcd,
                   vecs[i].exp_num, vecs[i].exp_den, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Consumer stall: result must hold and new inputs must be ignored.
        out_ready = 1'b0;
        applyStimulus(42, 18, 6);
        waitResult(lat, gn, gd, ge);
        checkOutput("hold_first_num", gn, 7);
        checkOutput("hold_first_lat", lat, FULL_LAT);
        for (int c = 0; c < 5; c++) begin
            num_i    = WIDTH'(1);
            den_i    = WIDTH'(1);
            gcd_i    = WIDTH'(1);
            in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput($sformatf("hold%0d_num", c), int'(num_o), 7);
            checkOutput($sformatf("hold%0d_den", c), int'(den_o), 3);
            checkOutput($sformatf("hold%0d_valid", c), int'(out_valid), 1);
            checkOutput($sformatf("hold%0d_in_ready", c), int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_in_ready", int'(in_ready), 1);
        checkOutput("release_out_valid", int'(out_valid), 0);
        checkOutput("release_num_kept", int'(num_o), 7);
        checkOutput("release_den_kept", int'(den_o), 3);

        // Reset in the middle of a divide.
        applyStimulus(42, 18, 6);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("mid_div_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_in_ready", int'(in_ready), 1);
        checkOutput("abort_num_o", int'(num_o), 0);
        checkOutput("abort_den_o", int'(den_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_no_late_valid", int'(out_valid), 0);
        runJob("after_reset", 100, 75, 25, 4, 3, 0, FULL_LAT);

        for (int r = 0; r < 40; r++) begin
            mode = int'($urandom_range(0, 3));
            if (mode < 2) begin
                g = mode;
                n = int'($urandom_range(0, 65535));
                d = int'($urandom_range(0, 65535));
            end else begin
                g = int'($urandom_range(2, 300));
                n = g * int'($urandom_range(0, 200));
                d = g * int'($urandom_range(0, 200));
                if (mode == 3) begin
                    n = n + int'($urandom_range(0, g - 1));
                    d = d + int'($urandom_range(0, g - 1));
                end
            end
            model(n, d, g, en, ed, ee, elat);
            runJob($sformatf("rand%0d_%0d_%0d_%0d", r, n, d, g), n, d, g, en, ed, ee, elat);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
